// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage execute pipeline around an external 32-bit ripple ALU.
// S1 registers the decoded op and drives the ALU control/operand ports. S2
// registers the ALU result, the destination tag and the {N,Z,C,V} status flags.
// Optional build macro: ALU_EXEC_STATS_EN adds OpCount/StallCount outputs.
module alu_exec_stage #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InA,
    input  logic [DATA_W-1:0] InB,
    input  logic [3:0]        InFunc,
    input  logic [DEST_W-1:0] InDest,
    input  logic              InSetFlags,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    output logic              AluAInvert,
    output logic              AluBNegate,
    output logic [1:0]        AluOp,
    input  logic [DATA_W-1:0] AluResult,
    input  logic              AluZero,
    input  logic              AluOverflow,
    input  logic              AluCarryOut,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutResult,
    output logic [DEST_W-1:0] OutDest,
    output logic [3:0]        Flags,
    output logic              ErrIllegal
`ifdef ALU_EXEC_STATS_EN
    ,
    output logic [31:0]       OpCount,
    output logic [31:0]       StallCount
`endif
);

    // Issue-stage function codes; 8..15 are illegal.
    localparam logic [3:0] FN_AND  = 4'd0;
    localparam logic [3:0] FN_OR   = 4'd1;
    localparam logic [3:0] FN_ADD  = 4'd2;
    localparam logic [3:0] FN_SUB  = 4'd3;
    localparam logic [3:0] FN_SLT  = 4'd4;
    localparam logic [3:0] FN_NOR  = 4'd5;
    localparam logic [3:0] FN_NAND = 4'd6;
    localparam logic [3:0] FN_CMP  = 4'd7;

    // Decoded view of the incoming op.
    logic              w_dec_ainv;
    logic              w_dec_bneg;
    logic [1:0]        w_dec_op;
    logic              w_dec_arith;   // op updates C and V
    logic              w_dec_beat;    // op produces a writeback beat
    logic              w_dec_illegal;
    logic [DATA_W-1:0] w_dec_a;
    logic [DATA_W-1:0] w_dec_b;

    // S1 operand stage.
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic              r_s1_ainv;
    logic              r_s1_bneg;
    logic [1:0]        r_s1_op;
    logic [DEST_W-1:0] r_s1_dest;
    logic              r_s1_setf;
    logic              r_s1_arith;
    logic              r_s1_beat;
    logic              r_s1_illegal;

    // S2 result stage.
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_out_result;
    logic [DEST_W-1:0] r_out_dest;
    logic [3:0]        r_flags;
    logic              r_err_illegal;

    logic w_in_fire;
    logic w_s2_load;

    // S1 may drain into S2 when S2 is empty or its beat is being taken.
    assign w_s2_load = r_s1_valid & (~r_s2_valid | OutReady);
    assign InReady   = ~r_s1_valid | w_s2_load;
    assign w_in_fire = InValid & InReady;

    // Map the issue function code onto {AInvert, BNegate, Op} and op attributes.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned, which would infer a latch.
        w_dec_ainv    = 1'b0;
        w_dec_bneg    = 1'b0;
        w_dec_op      = 2'b00;
        w_dec_arith   = 1'b0;
        w_dec_beat    = 1'b1;
        w_dec_illegal = 1'b0;
        case (InFunc)
            FN_AND:  w_dec_op = 2'b00;
            FN_OR:   w_dec_op = 2'b01;
            FN_ADD: begin
                w_dec_op    = 2'b10;
                w_dec_arith = 1'b1;
            end
            FN_SUB: begin
                w_dec_bneg  = 1'b1;
                w_dec_op    = 2'b10;
                w_dec_arith = 1'b1;
            end
            FN_SLT: begin
                w_dec_bneg = 1'b1;
                w_dec_op   = 2'b11;
            end
            FN_NOR: begin
                w_dec_ainv = 1'b1;
                w_dec_bneg = 1'b1;
                w_dec_op   = 2'b00;
            end
            FN_NAND: begin
                w_dec_ainv = 1'b1;
                w_dec_bneg = 1'b1;
                w_dec_op   = 2'b01;
            end
            FN_CMP: begin
                w_dec_bneg  = 1'b1;
                w_dec_op    = 2'b10;
                w_dec_arith = 1'b1;
                w_dec_beat  = 1'b0;
            end
            default: begin
                w_dec_illegal = 1'b1;
                w_dec_beat    = 1'b0;
            end
        endcase
        // Illegal ops present a quiet all-zero operand pair to the ALU.
        w_dec_a = w_dec_illegal ? '0 : InA;
        w_dec_b = w_dec_illegal ? '0 : InB;
    end

    // S1 register: capture on handshake, empty when the op moves on to S2.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            // NOTE: datapath registers are reset too because they drive the Alu* ports, which must read 0 in reset.
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_ainv    <= 1'b0;
            r_s1_bneg    <= 1'b0;
            r_s1_op      <= 2'b00;
            r_s1_dest    <= '0;
            r_s1_setf    <= 1'b0;
            r_s1_arith   <= 1'b0;
            r_s1_beat    <= 1'b0;
            r_s1_illegal <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            if (w_in_fire) begin
                r_s1_valid   <= 1'b1;
                r_s1_a       <= w_dec_a;
                r_s1_b       <= w_dec_b;
                r_s1_ainv    <= w_dec_ainv;
                r_s1_bneg    <= w_dec_bneg;
                r_s1_op      <= w_dec_op;
                r_s1_dest    <= InDest;
                r_s1_setf    <= InSetFlags;
                r_s1_arith   <= w_dec_arith;
                r_s1_beat    <= w_dec_beat;
                r_s1_illegal <= w_dec_illegal;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // S2 register: capture ALU result and flags on transfer, drop beat once taken.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_s2_valid    <= 1'b0;
            r_out_result  <= '0;
            r_out_dest    <= '0;
            r_flags       <= 4'b0000;
            r_err_illegal <= 1'b0;
        end else begin
            r_err_illegal <= w_s2_load & r_s1_illegal;
            if (w_s2_load) begin
                // CMP and illegal ops retire here without raising a beat.
                r_s2_valid <= r_s1_beat;
                if (r_s1_beat) begin
                    r_out_result <= AluResult;
                    r_out_dest   <= r_s1_dest;
                end
                if (r_s1_setf && !r_s1_illegal) begin
                    r_flags[3] <= AluResult[DATA_W-1];
                    r_flags[2] <= AluZero;
                    // Logic ops and SLT leave C and V untouched.
                    if (r_s1_arith) begin
                        r_flags[1] <= AluCarryOut;
                        r_flags[0] <= AluOverflow;
                    end
                end
            end else if (OutReady) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign AluA       = r_s1_a;
    assign AluB       = r_s1_b;
    assign AluAInvert = r_s1_ainv;
    assign AluBNegate = r_s1_bneg;
    assign AluOp      = r_s1_op;
    assign OutValid   = r_s2_valid;
    assign OutResult  = r_out_result;
    assign OutDest    = r_out_dest;
    assign Flags      = r_flags;
    assign ErrIllegal = r_err_illegal;

`ifdef ALU_EXEC_STATS_EN
    logic [31:0] r_op_count;
    logic [31:0] r_stall_count;

    // Count S1->S2 transfers and cycles where a beat waits on writeback.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_op_count    <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_s2_load) begin
                r_op_count <= r_op_count + 32'd1;
            end
            if (r_s2_valid && !OutReady) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign OpCount    = r_op_count;
    assign StallCount = r_stall_count;
`endif

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Two-stage execute pipeline that wraps the 32-bit ripple ALU.
- Captures decoded ops from the issue stage using a valid/ready handshake, then drives the ALU control lines (Op, AInvert, BNegate) from a registered operand stage.
- Registers the ALU result and the N/Z/C/V status flags for the writeback stage.
- Throughput is one op per cycle; OutReady backpressure propagates upstream.

Parameters:
- DATA_W, 32: operand/result width; must equal the ALU width.
- DEST_W, 5: destination register tag width.

Ports:
- Clock  in  1  rising-edge clock
- ResetN  in  1  asynchronous active-low reset
- InValid  in  1  issue stage presents an op
- InReady  out  1  stage accepts an op this cycle
- InA  in  DATA_W  operand A
- InB  in  DATA_W  operand B
- InFunc  in  4  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 NAND, 7 CMP, 8-15 illegal
- InDest  in  DEST_W  destination tag
- InSetFlags  in  1  op updates Flags
- AluA  out  DATA_W  to ALU A
- AluB  out  DATA_W  to ALU B
- AluAInvert  out  1  to ALU AInvert
- AluBNegate  out  1  to ALU BNegate
- AluOp  out  2  to ALU Op
- AluResult  in  DATA_W  from ALU Result
- AluZero  in  1  from ALU Zero
- AluOverflow  in  1  from ALU Overflow
- AluCarryOut  in  1  from ALU CarryOut
- OutValid  out  1  result beat valid
- OutReady  in  1  writeback accepts the beat
- OutResult  out  DATA_W  registered result
- OutDest  out  DEST_W  registered tag
- Flags  out  4  {N,Z,C,V} status register
- ErrIllegal  out  1  one-cycle pulse when an illegal op retires

Behaviour:
- Reset (async, ResetN=0):
  - S1.valid=0, S2.valid=0.
  - OutValid=0, OutResult=0, OutDest=0, Flags=4'b0000, ErrIllegal=0.
  - AluA, AluB, AluAInvert, AluBNegate and AluOp all 0.
  - Reset mid-operation discards all in-flight ops; no beat is emitted after release.
- Decode {AInvert, BNegate, Op}, registered into S1:
  - AND=000_00, OR=000_01, ADD=000_10, SUB=010_10, SLT=010_11
  - NOR=110_00, NAND=110_01, CMP=010_10
  - illegal=000_00, and ALU inputs are forced to 0.
- S1 (operand register):
  - Loads on InValid&InReady.
  - Drives the Alu* ports directly from its registers. The ALU path is combinational S1->S2.
- S2 (result register):
  - s2_load = S1.valid & (~S2.valid | OutReady).
  - InReady = ~S1.valid | s2_load (combinational).
- Latency: input handshake in cycle t gives OutValid in cycle t+2 when there is no backpressure.
- Hold while stalled: with OutValid=1 and OutReady=0, OutResult and OutDest hold. S1 holds. InReady=0 if S1 is occupied.
- CMP:
  - Passes S1->S2 and updates Flags (when InSetFlags=1).
  - Produces no output beat: S2.valid stays 0.
- Illegal op:
  - Retires with no beat and no flag update.
  - ErrIllegal pulses in the S1->S2 transfer cycle.
- Flags update in the S1->S2 transfer cycle, only if InSetFlags=1 and the op is legal:
  - N = AluResult[DATA_W-1]; Z = AluZero.
  - ADD/SUB/CMP: C = AluCarryOut (SUB: C=1 means no borrow); V = AluOverflow.
  - AND/OR/NOR/NAND/SLT: C and V keep their previous values.
- SLT result is 0 or 1. The ALU's internal Set path is not corrected for overflow; this is accepted.
- Simultaneous events:
  - A new op may enter S1 in the same cycle S1 empties into S2.
  - S2 may accept a new op in the same cycle its old beat is taken.
- Arithmetic wraps modulo 2^DATA_W.

Optional Feature:
- ALU_EXEC_STATS_EN defined: adds two outputs, OpCount[31:0] and StallCount[31:0].
  - OpCount increments on each S1->S2 transfer.
  - StallCount increments each cycle where OutValid&~OutReady.
  - Both reset to 0 and wrap at 2^32.
- ALU_EXEC_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADD A=0x7FFFFFFF, B=1, SetFlags -> at t+2 OutResult=0x80000000, Flags N=1 Z=0 C=0 V=1.
- SUB A=5, B=5, SetFlags -> OutResult=0, Flags Z=1 C=1 V=0; follow with AND 0xF0F0,0x0FF0 -> 0x00F0, C=1 V=0 retained.
- CMP A=3, B=7 -> no OutValid pulse; Flags N=1 C=0 Z=0; next op's beat arrives normally.
- Back-to-back 4 ADDs with OutReady=0 for 3 cycles -> InReady drops after 2 accepted, OutResult stable, all 4 results in order after release.
- InFunc=12 -> ErrIllegal one pulse, no beat, Flags unchanged; ResetN low with 2 ops in flight -> OutValid=0, Flags=0, no beat after release.
- With ALU_EXEC_STATS_EN: 4 ops, 3 stall cycles -> OpCount=4, StallCount=3.
